// File: rtl/ssim_stats_accum_if.sv
// Sample/sum handshake bundle between the SSIM pixel feeders, the statistics
// accumulator and the mean/variance arithmetic stage.
interface ssim_stats_accum_if #(
    parameter int unsigned PIX_WIDTH = 8,
    parameter int unsigned ACC_WIDTH = 32
);
    logic [PIX_WIDTH-1:0] in_x;
    logic [PIX_WIDTH-1:0] in_y;
    logic                 in_valid;
    logic                 in_ready;
    logic [ACC_WIDTH-1:0] sum_x;
    logic [ACC_WIDTH-1:0] sum_y;
    logic [ACC_WIDTH-1:0] sum_xx;
    logic [ACC_WIDTH-1:0] sum_yy;
    logic [ACC_WIDTH-1:0] sum_xy;
    logic                 out_valid;
    logic                 out_ready;

    // Feeder / consumer side: drives samples and the consume strobe.
    modport master (
        output in_x, in_y, in_valid, out_ready,
        input  in_ready, sum_x, sum_y, sum_xx, sum_yy, sum_xy, out_valid
    );

    // Accumulator side.
    modport slave (
        input  in_x, in_y, in_valid, out_ready,
        output in_ready, sum_x, sum_y, sum_xx, sum_yy, sum_xy, out_valid
    );
endinterface

// File: rtl/ssim_stats_accum.sv
// SSIM frame statistics accumulator: sums x, y (and x*x, y*y, x*y when the
// SSIM_SECOND_ORDER_EN macro is defined) over NUM paired samples, then holds
// the sums behind a valid/ready handshake until the downstream stage takes them.
module ssim_stats_accum #(
    parameter int unsigned PIX_WIDTH = 8,
    parameter int unsigned NUM       = 784,
    parameter int unsigned ACC_WIDTH = 32
) (
    input logic                clk,
    input logic                clr,
    ssim_stats_accum_if.slave  bus
);
    localparam int unsigned CNT_W  = $clog2(NUM + 1);
`ifdef SSIM_SECOND_ORDER_EN
    localparam int unsigned PROD_W = 2 * PIX_WIDTH;
`endif

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 out_valid_q;

    logic                 s1_valid_q;
    logic [PIX_WIDTH-1:0] s1_x_q;
    logic [PIX_WIDTH-1:0] s1_y_q;
    logic [ACC_WIDTH-1:0] acc_x_q,  acc_x_d;
    logic [ACC_WIDTH-1:0] acc_y_q,  acc_y_d;

`ifdef SSIM_SECOND_ORDER_EN
    logic [PROD_W-1:0]    s1_xx_q;
    logic [PROD_W-1:0]    s1_yy_q;
    logic [PROD_W-1:0]    s1_xy_q;
    logic [ACC_WIDTH-1:0] acc_xx_q, acc_xx_d;
    logic [ACC_WIDTH-1:0] acc_yy_q, acc_yy_d;
    logic [ACC_WIDTH-1:0] acc_xy_q, acc_xy_d;
`endif

    logic in_ready_c;
    logic accept_c;
    logic last_c;

    assign in_ready_c = (state_q == ST_ACCUM);
    assign accept_c   = bus.in_valid && in_ready_c;
    assign last_c     = (cnt_q == CNT_W'(NUM - 1));

    // Stage-2 adders: fold the stage-1 entry into the running sums (wrapping).
    always_comb begin
        acc_x_d = acc_x_q;
        acc_y_d = acc_y_q;
        if (s1_valid_q) begin
            acc_x_d = acc_x_q + ACC_WIDTH'(s1_x_q);
            acc_y_d = acc_y_q + ACC_WIDTH'(s1_y_q);
        end
    end

`ifdef SSIM_SECOND_ORDER_EN
    // Second-order adders, zero-extending each 2*PIX_WIDTH product.
    always_comb begin
        acc_xx_d = acc_xx_q;
        acc_yy_d = acc_yy_q;
        acc_xy_d = acc_xy_q;
        if (s1_valid_q) begin
            acc_xx_d = acc_xx_q + ACC_WIDTH'(s1_xx_q);
            acc_yy_d = acc_yy_q + ACC_WIDTH'(s1_yy_q);
            acc_xy_d = acc_xy_q + ACC_WIDTH'(s1_xy_q);
        end
    end

    // Stage-1 multipliers and second-order accumulators.
    always_ff @(posedge clk) begin
        if (clr) begin
            acc_xx_q <= '0;
            acc_yy_q <= '0;
            acc_xy_q <= '0;
        end else begin
            if (accept_c) begin
                s1_xx_q <= PROD_W'(bus.in_x) * PROD_W'(bus.in_x);
                s1_yy_q <= PROD_W'(bus.in_y) * PROD_W'(bus.in_y);
                s1_xy_q <= PROD_W'(bus.in_x) * PROD_W'(bus.in_y);
            end
            if (state_q == ST_HOLD && out_valid_q && bus.out_ready) begin
                acc_xx_q <= '0;
                acc_yy_q <= '0;
                acc_xy_q <= '0;
            end else begin
                acc_xx_q <= acc_xx_d;
                acc_yy_q <= acc_yy_d;
                acc_xy_q <= acc_xy_d;
            end
        end
    end

    assign bus.sum_xx = acc_xx_q;
    assign bus.sum_yy = acc_yy_q;
    assign bus.sum_xy = acc_xy_q;
`else
    assign bus.sum_xx = '0;
    assign bus.sum_yy = '0;
    assign bus.sum_xy = '0;
`endif

    // Frame FSM, sample counter, stage-1 capture and first-order accumulators.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_ACCUM;
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            acc_x_q     <= '0;
            acc_y_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= accept_c;
            if (accept_c) begin
                s1_x_q <= bus.in_x;
                s1_y_q <= bus.in_y;
            end
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;

            case (state_q)
                ST_ACCUM: begin
                    if (accept_c) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_c) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Consume only after out_valid has been visible for a cycle.
                    if (out_valid_q && bus.out_ready) begin
                        state_q     <= ST_ACCUM;
                        cnt_q       <= '0;
                        acc_x_q     <= '0;
                        acc_y_q     <= '0;
                        out_valid_q <= 1'b0;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_ACCUM;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.sum_x     = acc_x_q;
    assign bus.sum_y     = acc_y_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_ssim_stats_accum.sv
// Directed + randomized bench for ssim_stats_accum; follows SSIM_SECOND_ORDER_EN.
module tb_ssim_stats_accum;
    localparam int unsigned PIX_WIDTH = 8;
    localparam int unsigned NUM       = 784;
    localparam int unsigned ACC_WIDTH = 32;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    ssim_stats_accum_if #(.PIX_WIDTH(PIX_WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus ();

    ssim_stats_accum #(
        .PIX_WIDTH(PIX_WIDTH),
        .NUM      (NUM),
        .ACC_WIDTH(ACC_WIDTH)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Samples the model believes were accepted in the current frame.
    int unsigned qx[$];
    int unsigned qy[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference sums computed straight from the accepted sample list.
    task automatic check_sums(input string tag);
        logic [63:0] sx, sy, sxx, syy, sxy, mask;
        mask = (64'd1 << ACC_WIDTH) - 64'd1;
        sx = 0; sy = 0; sxx = 0; syy = 0; sxy = 0;
        foreach (qx[i]) begin
            sx  += 64'(qx[i]);
            sy  += 64'(qy[i]);
            sxx += 64'(qx[i]) * 64'(qx[i]);
            syy += 64'(qy[i]) * 64'(qy[i]);
            sxy += 64'(qx[i]) * 64'(qy[i]);
        end
`ifndef SSIM_SECOND_ORDER_EN
        sxx = 0; syy = 0; sxy = 0;
`endif
        chk({tag, "_sum_x"},  64'(bus.sum_x),  sx  & mask);
        chk({tag, "_sum_y"},  64'(bus.sum_y),  sy  & mask);
        chk({tag, "_sum_xx"}, 64'(bus.sum_xx), sxx & mask);
        chk({tag, "_sum_yy"}, 64'(bus.sum_yy), syy & mask);
        chk({tag, "_sum_xy"}, 64'(bus.sum_xy), sxy & mask);
    endtask

    // One accepted sample: in_ready must be high while the frame is open.
    task automatic send(input int unsigned x, input int unsigned y);
        bus.in_x     = PIX_WIDTH'(x);
        bus.in_y     = PIX_WIDTH'(y);
        bus.in_valid = 1'b1;
        chk("in_ready_open", 64'(bus.in_ready), 64'd1);
        step();
        qx.push_back(x);
        qy.push_back(y);
    endtask

    // Full frame. mode: 0 constant (cx,cy), 1 ramp, 2 random.
    // gap: 0 none, 1 every other cycle, 2 random idles.
    task automatic run_frame(input string tag, input int mode, input int gap,
                             input int unsigned cx, input int unsigned cy);
        int unsigned x, y;
        qx.delete();
        qy.delete();
        for (int i = 0; i < int'(NUM); i++) begin
            if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 2) == 0)) begin
                bus.in_valid = 1'b0;
                bus.in_x     = PIX_WIDTH'($urandom);
                step();
            end
            case (mode)
                0:       begin x = cx; y = cy; end
                1:       begin x = i % 256; y = 255 - (i % 256); end
                default: begin x = $urandom_range(0, 255); y = $urandom_range(0, 255); end
            endcase
            send(x, y);
        end
        bus.in_valid = 1'b0;
        // Last accept at edge T; in_ready drops now, out_valid rises after T+2.
        chk({tag, "_in_ready_T"},  64'(bus.in_ready),  64'd0);
        chk({tag, "_out_valid_T"}, 64'(bus.out_valid), 64'd0);
        step();
        chk({tag, "_out_valid_T1"}, 64'(bus.out_valid), 64'd0);
        step();
        chk({tag, "_out_valid_T2"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_in_ready_T2"},  64'(bus.in_ready),  64'd0);
        check_sums(tag);
    endtask

    // Consume the held sums with a single out_ready strobe (or tied-high).
    task automatic release_sums(input string tag, input logic keep_ready);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = keep_ready;
        chk({tag, "_rel_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_rel_in_ready"},  64'(bus.in_ready),  64'd1);
    endtask

    initial begin
        clr          = 1'b1;
        bus.in_x     = '0;
        bus.in_y     = '0;
        bus.in_valid = 1'b0;
        bus.out_ready= 1'b0;
        step();
        step();
        clr = 1'b0;
        qx.delete();
        qy.delete();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check_sums("rst");

        // Saturated pixels, continuous valid.
        run_frame("s1", 0, 0, 255, 255);
        chk("s1_abs_sum_x", 64'(bus.sum_x), 64'd199920);
`ifdef SSIM_SECOND_ORDER_EN
        chk("s1_abs_sum_xy", 64'(bus.sum_xy), 64'd50979600);
`else
        chk("s1_abs_sum_xy", 64'(bus.sum_xy), 64'd0);
`endif
        release_sums("s1", 1'b0);

        // Valid every other cycle.
        run_frame("s2", 0, 1, 1, 2);
        chk("s2_abs_sum_y", 64'(bus.sum_y), 64'd1568);
        release_sums("s2", 1'b0);

        // HOLD with trailing padding offered; nothing may be absorbed.
        run_frame("s3", 0, 0, 9, 4);
        bus.in_x     = 8'd7;
        bus.in_y     = 8'd7;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("s3_hold_in_ready",  64'(bus.in_ready),  64'd0);
            chk("s3_hold_out_valid", 64'(bus.out_valid), 64'd1);
        end
        check_sums("s3_hold");
        bus.in_valid = 1'b0;
        release_sums("s3", 1'b0);
        run_frame("s3z", 0, 0, 0, 0);
        release_sums("s3z", 1'b0);

        // clr after 100 samples, coincident with an offered sample.
        qx.delete();
        qy.delete();
        for (int i = 0; i < 100; i++) send(10, 10);
        clr          = 1'b1;
        bus.in_valid = 1'b1;
        step();
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        qx.delete();
        qy.delete();
        chk("s4_clr_out_valid", 64'(bus.out_valid), 64'd0);
        chk("s4_clr_in_ready",  64'(bus.in_ready),  64'd1);
        check_sums("s4_clr");
        step();
        check_sums("s4_clr_settle");
        run_frame("s4", 0, 0, 3, 5);
        chk("s4_abs_sum_x", 64'(bus.sum_x), 64'd2352);
        release_sums("s4", 1'b0);

        // out_ready tied high, two back-to-back ramp frames.
        bus.out_ready = 1'b1;
        run_frame("s5a", 1, 0, 0, 0);
        step();
        chk("s5a_pulse_out_valid", 64'(bus.out_valid), 64'd0);
        chk("s5a_pulse_in_ready",  64'(bus.in_ready),  64'd1);
        run_frame("s5b", 1, 0, 0, 0);
        step();
        chk("s5b_pulse_out_valid", 64'(bus.out_valid), 64'd0);
        chk("s5b_pulse_in_ready",  64'(bus.in_ready),  64'd1);
        bus.out_ready = 1'b0;

        // Random data with random idle cycles.
        run_frame("rnd", 2, 2, 0, 0);
        release_sums("rnd", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
